// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel plus the decode-side handshake.
// The master modport is the fetch unit; the slave modport is memory/decode.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned IMM_W   = 12
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               stall;
  logic               decode_ready;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_target;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [IMM_W-1:0]   imm12_out;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, imm12_out, pc_out,
    input  imem_ack, imem_rdata, stall, decode_ready, jump_en, jump_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, imm12_out, pc_out,
    output imem_ack, imem_rdata, stall, decode_ready, jump_en, jump_target
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one req/ack fetch at a time and presents the
// fetched word (with its PC and 12-bit immediate) to decode until it is consumed.
module instr_fetch_unit #(
  parameter int unsigned     ADDR_W   = 16,
  parameter int unsigned     INSTR_W  = 16,
  parameter int unsigned     IMM_W    = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [ADDR_W-1:0]  redirect_pc;

  // State and all visible outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      imm_q    <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      imm_q    <= imm_d;
      pc_out_q <= pc_out_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a transition fires.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    imm_d       = imm_q;
    pc_out_d    = pc_out_q;
    redirect_pc = bus.jump_en ? bus.jump_target : pc_q;

    case (state_q)
      IDLE: begin
        if (!bus.stall) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = REQ;
        end
      end

      // An issued request stays up, address frozen, until memory acks it.
      REQ: begin
        if (bus.imem_ack) begin
          instr_d  = bus.imem_rdata;
          imm_d    = bus.imem_rdata[IMM_W-1:0];
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          req_d    = 1'b0;
          pc_d     = pc_q + ADDR_W'(1);
          state_d  = HOLD;
        end
      end

      // A jump is only taken on the cycle decode consumes the held instruction.
      HOLD: begin
        if (bus.decode_ready) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          if (!bus.stall) begin
            req_d   = 1'b1;
            addr_d  = redirect_pc;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_out   = instr_q;
  assign bus.imm12_out   = imm_q;
  assign bus.pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (RESET_PC 0x0000 and 0xFFFF) share one
// stimulus stream and are checked every cycle against a flag-based fetch model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        decode_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [15:0] jump_target = 16'h0000;
  logic        ack = 1'b0;
  logic [15:0] rdata = 16'h0000;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if ifa ();
  instr_fetch_unit_if ifb ();

  assign ifa.imem_ack     = ack;
  assign ifa.imem_rdata   = rdata;
  assign ifa.stall        = stall;
  assign ifa.decode_ready = decode_ready;
  assign ifa.jump_en      = jump_en;
  assign ifa.jump_target  = jump_target;
  assign ifb.imem_ack     = ack;
  assign ifb.imem_rdata   = rdata;
  assign ifb.stall        = stall;
  assign ifb.decode_ready = decode_ready;
  assign ifb.jump_en      = jump_en;
  assign ifb.jump_target  = jump_target;

  instr_fetch_unit #(.RESET_PC(16'h0000)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
  instr_fetch_unit #(.RESET_PC(16'hFFFF)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

  // Model: "requesting" and "presenting" flags plus the PC bookkeeping.
  logic [15:0] rst_pc  [2] = '{16'h0000, 16'hFFFF};
  logic [15:0] m_pc    [2];
  logic        m_req   [2];
  logic [15:0] m_addr  [2];
  logic        m_valid [2];
  logic [15:0] m_instr [2];
  logic [15:0] m_pcout [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = rst_pc[k]; m_req[k] = 1'b0; m_addr[k] = rst_pc[k];
      m_valid[k] = 1'b0; m_instr[k] = 16'h0000; m_pcout[k] = 16'h0000;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    for (int k = 0; k < 2; k++) begin
      if (m_valid[k]) begin
        if (decode_ready) begin
          m_valid[k] = 1'b0;
          if (jump_en) m_pc[k] = jump_target;
          if (!stall) begin m_req[k] = 1'b1; m_addr[k] = m_pc[k]; end
        end
      end else if (m_req[k]) begin
        if (ack) begin
          m_instr[k] = rdata; m_pcout[k] = m_pc[k]; m_valid[k] = 1'b1;
          m_req[k] = 1'b0; m_pc[k] = m_pc[k] + 16'd1;
        end
      end else if (!stall) begin
        m_req[k] = 1'b1; m_addr[k] = m_pc[k];
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic r, v;
      logic [15:0] a, ins, pco;
      logic [11:0] im;
      if (k == 0) begin
        r = ifa.imem_req; a = ifa.imem_addr; v = ifa.instr_valid;
        ins = ifa.instr_out; im = ifa.imm12_out; pco = ifa.pc_out;
      end else begin
        r = ifb.imem_req; a = ifb.imem_addr; v = ifb.instr_valid;
        ins = ifb.instr_out; im = ifb.imm12_out; pco = ifb.pc_out;
      end
      check($sformatf("u%0d imem_req", k), 32'(r), 32'(m_req[k]));
      check($sformatf("u%0d imem_addr", k), 32'(a), 32'(m_addr[k]));
      check($sformatf("u%0d instr_valid", k), 32'(v), 32'(m_valid[k]));
      if (m_valid[k]) begin
        check($sformatf("u%0d instr_out", k), 32'(ins), 32'(m_instr[k]));
        check($sformatf("u%0d imm12_out", k), 32'(im), 32'(m_instr[k] & 16'h0FFF));
        check($sformatf("u%0d pc_out", k), 32'(pco), 32'(m_pcout[k]));
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (3) cyc();
    check("lit rst req", 32'(ifa.imem_req), 32'd0);
    check("lit rst addr a", 32'(ifa.imem_addr), 32'h0000);
    check("lit rst addr b", 32'(ifb.imem_addr), 32'hFFFF);
    check("lit rst valid", 32'(ifa.instr_valid), 32'd0);
    check("lit rst instr", 32'(ifa.instr_out), 32'd0);
    check("lit rst imm", 32'(ifa.imm12_out), 32'd0);
    check("lit rst pc_out", 32'(ifa.pc_out), 32'd0);

    rst_n = 1'b1;
    cyc();
    check("lit first req", 32'(ifa.imem_req), 32'd1);
    check("lit first addr", 32'(ifa.imem_addr), 32'h0000);
    check("lit wrap first addr", 32'(ifb.imem_addr), 32'hFFFF);

    // Sequential fetch
    ack = 1'b1; rdata = 16'hA123;
    cyc();
    check("lit seq valid", 32'(ifa.instr_valid), 32'd1);
    check("lit seq instr", 32'(ifa.instr_out), 32'hA123);
    check("lit seq imm", 32'(ifa.imm12_out), 32'h123);
    check("lit seq pc_out", 32'(ifa.pc_out), 32'h0000);
    check("lit wrap pc_out", 32'(ifb.pc_out), 32'hFFFF);
    ack = 1'b0; decode_ready = 1'b1;
    cyc();
    check("lit seq next addr", 32'(ifa.imem_addr), 32'h0001);
    check("lit wrap next addr", 32'(ifb.imem_addr), 32'h0000);

    // Jump
    ack = 1'b1; rdata = 16'($urandom); decode_ready = 1'b0;
    cyc();
    ack = 1'b0; decode_ready = 1'b1; jump_en = 1'b1; jump_target = 16'h0ABC;
    cyc();
    check("lit jump addr", 32'(ifa.imem_addr), 32'h0ABC);
    check("lit jump addr b", 32'(ifb.imem_addr), 32'h0ABC);
    jump_en = 1'b0; decode_ready = 1'b0; ack = 1'b1; rdata = 16'h5F00;
    cyc();
    check("lit jump pc_out", 32'(ifa.pc_out), 32'h0ABC);
    ack = 1'b0; decode_ready = 1'b1;
    cyc();
    check("lit after jump addr", 32'(ifa.imem_addr), 32'h0ABD);

    // Stall in IDLE, then slow ack with stall raised during REQ
    ack = 1'b1; decode_ready = 1'b0;
    cyc();
    ack = 1'b0; decode_ready = 1'b1; stall = 1'b1;
    cyc();
    decode_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("lit stall idle req", 32'(ifa.imem_req), 32'd0);
    end
    stall = 1'b0;
    cyc();
    check("lit unstall req", 32'(ifa.imem_req), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("lit slow req", 32'(ifa.imem_req), 32'd1);
      check("lit slow addr", 32'(ifa.imem_addr), 32'h0ABE);
    end
    ack = 1'b1; rdata = 16'h7777;
    cyc();
    check("lit slow pc_out", 32'(ifa.pc_out), 32'h0ABE);
    ack = 1'b0; stall = 1'b0; decode_ready = 1'b1;
    cyc();
    decode_ready = 1'b0;

    // Reset mid-request
    rst_n = 1'b0; ack = 1'b1;
    #1;
    model_reset();
    check("lit midrst req a", 32'(ifa.imem_req), 32'd0);
    check("lit midrst req b", 32'(ifb.imem_req), 32'd0);
    cyc();
    cyc();
    check("lit midrst valid", 32'(ifa.instr_valid), 32'd0);
    rst_n = 1'b1; ack = 1'b0;
    cyc();
    check("lit refetch addr", 32'(ifa.imem_addr), 32'h0000);
    check("lit refetch req", 32'(ifa.imem_req), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      stall        = ($urandom_range(0, 3) == 0);
      decode_ready = ($urandom_range(0, 1) == 1);
      jump_en      = ($urandom_range(0, 3) == 0);
      jump_target  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      ack          = ifa.imem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      rdata        = 16'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
